// File: rtl/mult_rr_sched.sv
// Signed multiplier: full-width product of two signed operands, purely combinational.
// Latency: 0 cycles.
// Backpressure: none, output follows inputs.
module multsigned #(
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8
) (
    input  logic signed [IN_SIZE_0-1:0]           a_i,
    input  logic signed [IN_SIZE_1-1:0]           b_i,
    output logic signed [IN_SIZE_0+IN_SIZE_1-1:0] p_o
);
    localparam int OUT_SIZE = IN_SIZE_0 + IN_SIZE_1;

    // Both operands sign-extended to full width first, so the product is exact.
    assign p_o = OUT_SIZE'(a_i) * OUT_SIZE'(b_i);
endmodule

// Round-robin scheduler sharing one signed multiplier among NUM_REQ valid/ready requesters.
// Latency: accept at edge N -> registered product with resp_valid_o high after edge N+1.
// Backpressure: resp_ready_i low holds RESP with stable data/id and blocks every grant.
module mult_rr_sched #(
    parameter int NUM_REQ   = 4,
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8,
    localparam int OUT_SIZE = IN_SIZE_0 + IN_SIZE_1,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*IN_SIZE_0-1:0]   req_a_i,
    input  logic [NUM_REQ*IN_SIZE_1-1:0]   req_b_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [ID_W-1:0]                resp_id_o,
    output logic [OUT_SIZE-1:0]            resp_data_o,
    output logic                           busy_o
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    typedef struct packed {
        logic signed [IN_SIZE_1-1:0] b;
        logic signed [IN_SIZE_0-1:0] a;
    } op_t;

    state_t                     state_q, state_d;
    op_t                        op_q, op_d;
    logic [ID_W-1:0]            id_q, id_d;
    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic signed [OUT_SIZE-1:0] prod_q, prod_d;
    logic signed [OUT_SIZE-1:0] mult_p;
    logic                       can_accept;
    logic                       accept;
    logic                       grant_found;
    logic [ID_W-1:0]            grant_id;

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin : arb
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // Reset term keeps req_ready_o low while reset is held, even with valids up.
    assign can_accept = rst_ni & ((state_q == IDLE) | ((state_q == RESP) & resp_ready_i));
    assign accept     = can_accept & grant_found;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        prod_d   = prod_q;
        case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: begin
                prod_d  = mult_p;
                state_d = RESP;
            end
            RESP: if (resp_ready_i) state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            op_d.a   = req_a_i[grant_id*IN_SIZE_0 +: IN_SIZE_0];
            op_d.b   = req_b_i[grant_id*IN_SIZE_1 +: IN_SIZE_1];
            id_d     = grant_id;
            rr_ptr_d = grant_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= '0;
            id_q     <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            prod_q   <= prod_d;
        end
    end

    multsigned #(
        .IN_SIZE_0 (IN_SIZE_0),
        .IN_SIZE_1 (IN_SIZE_1)
    ) u_mult (
        .a_i (op_q.a),
        .b_i (op_q.b),
        .p_o (mult_p)
    );

    assign resp_valid_o = (state_q == RESP);
    assign resp_id_o    = id_q;
    assign resp_data_o  = prod_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_mult_rr_sched.sv
// Bench for mult_rr_sched: directed vector table, hand sequences, randomized transaction model.
module tb_mult_rr_sched;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int BW = 8;
    localparam int PW = 12;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N*AW-1:0] req_a_i;
    logic [N*BW-1:0] req_b_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [1:0]      resp_id_o;
    logic [PW-1:0]   resp_data_o;
    logic            busy_o;

    logic [AW-1:0]   va [N];
    logic [BW-1:0]   vb [N];
    int              checks = 0;
    int              errors = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_a_i[k*AW +: AW] = va[k];
            req_b_i[k*BW +: BW] = vb[k];
        end
    end

    mult_rr_sched dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_id_o    (resp_id_o),
        .resp_data_o  (resp_data_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [PW-1:0] prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
        int r;
        r = $signed(a) * $signed(b);
        return r[PW-1:0];
    endfunction

    typedef struct {
        int            req;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [PW-1:0] p;
    } vec_t;

    vec_t tbl [6];

    // Random-phase model state
    bit            have_txn;
    int            age;
    int            txn_id;
    logic [PW-1:0] txn_p;
    int            last_g;
    int            resp_cnt;
    int            cyc;
    int            g;
    int            idx;
    bit            exp_rv;
    bit            can;
    logic [PW-1:0] held_data;

    initial begin
        tbl[0] = '{2, 4'hD, 8'd100, 12'hED4};
        tbl[1] = '{0, 4'h8, 8'h80,  12'h400};
        tbl[2] = '{1, 4'h7, 8'h80,  12'hC80};
        tbl[3] = '{3, 4'h8, 8'h7F,  12'hC08};
        tbl[4] = '{1, 4'h5, 8'h00,  12'h000};
        tbl[5] = '{0, 4'hF, 8'hFF,  12'h001};

        for (int k = 0; k < N; k++) begin
            va[k] = '0;
            vb[k] = '0;
        end
        rst_ni       = 1'b0;
        req_valid_i  = '0;
        resp_ready_i = 1'b0;
        #1;
        chk("rst_ready", req_ready_o, 0);
        chk("rst_valid", resp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", resp_data_o, 0);
        chk("rst_id", resp_id_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Directed single transactions
        for (int t = 0; t < 6; t++) begin
            va[tbl[t].req] = tbl[t].a;
            vb[tbl[t].req] = tbl[t].b;
            req_valid_i    = 4'(1 << tbl[t].req);
            resp_ready_i   = 1'b1;
            #1;
            chk("vec_ready", req_ready_o, 32'(1 << tbl[t].req));
            tick();
            req_valid_i = '0;
            #1;
            chk("vec_calc_busy", busy_o, 1);
            chk("vec_calc_valid", resp_valid_o, 0);
            tick();
            chk("vec_resp_valid", resp_valid_o, 1);
            chk("vec_resp_data", resp_data_o, tbl[t].p);
            chk("vec_resp_id", resp_id_o, tbl[t].req);
            tick();
            chk("vec_idle_busy", busy_o, 0);
        end

        // Reset mid-stream while in RESP with all requesters valid
        va[1] = 4'h3; vb[1] = 8'h05;
        req_valid_i = 4'b0010;
        #1;
        tick();
        req_valid_i  = '0;
        tick();
        resp_ready_i = 1'b0;
        req_valid_i  = '1;
        rst_ni       = 1'b0;
        #1;
        chk("midrst_ready", req_ready_o, 0);
        chk("midrst_valid", resp_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_data", resp_data_o, 0);
        chk("midrst_id", resp_id_o, 0);
        tick();
        rst_ni       = 1'b1;
        resp_ready_i = 1'b1;
        va[0] = 4'h3; vb[0] = 8'hF6;
        va[1] = 4'hA; vb[1] = 8'd21;
        va[2] = 4'h7; vb[2] = 8'h81;
        va[3] = 4'hC; vb[3] = 8'hC4;
        #1;
        chk("first_grant", req_ready_o, 32'b0001);
        tick();

        // Fairness: back-to-back grants 0,1,2,3,0,1 every 2 cycles
        for (int n = 0; n < 6; n++) begin
            chk("fair_calc_ready", req_ready_o, 0);
            chk("fair_calc_valid", resp_valid_o, 0);
            tick();
            chk("fair_resp_valid", resp_valid_o, 1);
            chk("fair_resp_id", resp_id_o, n % 4);
            chk("fair_resp_data", resp_data_o, prod(va[n%4], vb[n%4]));
            chk("fair_next_grant", req_ready_o, 32'(1 << ((n + 1) % 4)));
            tick();
        end

        // Backpressure on requester 2's response
        resp_ready_i = 1'b0;
        #1;
        chk("bp_calc_ready", req_ready_o, 0);
        tick();
        held_data = prod(va[2], vb[2]);
        for (int n = 0; n < 5; n++) begin
            chk("bp_valid", resp_valid_o, 1);
            chk("bp_id", resp_id_o, 2);
            chk("bp_data", resp_data_o, held_data);
            chk("bp_ready", req_ready_o, 0);
            tick();
        end
        resp_ready_i = 1'b1;
        #1;
        chk("bp_release_grant", req_ready_o, 32'b1000);
        tick();
        req_valid_i = '0;
        tick();
        tick();
        chk("bp_drain_busy", busy_o, 0);

        // Reset while in CALC discards the in-flight product
        req_valid_i = 4'b0100;
        #1;
        chk("mid_op_grant", req_ready_o, 32'b0100);
        tick();
        req_valid_i = '0;
        chk("mid_op_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("mid_op_rst_busy", busy_o, 0);
        chk("mid_op_rst_valid", resp_valid_o, 0);
        tick();
        rst_ni = 1'b1;
        for (int n = 0; n < 4; n++) begin
            chk("mid_op_no_resp", resp_valid_o, 0);
            tick();
        end
        req_valid_i = '1;
        #1;
        chk("mid_op_rrptr", req_ready_o, 32'b0001);
        req_valid_i = '0;
        tick();

        // Randomized traffic against a transaction-level model
        have_txn = 1'b0;
        age      = 0;
        txn_id   = 0;
        txn_p    = '0;
        last_g   = N - 1;
        resp_cnt = 0;
        cyc      = 0;
        while (resp_cnt < 1000 && cyc < 20000) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid_i[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid_i[k] = 1'b1;
                        va[k] = AW'($urandom);
                        vb[k] = BW'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid_i[k] = 1'b0;
                end
            end
            resp_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            exp_rv = have_txn && (age >= 1);
            can    = !have_txn || (exp_rv && resp_ready_i);
            g      = -1;
            if (can) begin
                for (int i = 1; i <= N; i++) begin
                    idx = (last_g + i) % N;
                    if (g < 0 && req_valid_i[idx]) g = idx;
                end
            end
            chk("rnd_ready", req_ready_o, (g >= 0) ? 32'(1 << g) : 32'd0);
            chk("rnd_valid", resp_valid_o, 32'(exp_rv));
            chk("rnd_busy", busy_o, 32'(have_txn));
            if (exp_rv) begin
                chk("rnd_id", resp_id_o, txn_id);
                chk("rnd_data", resp_data_o, txn_p);
            end
            tick();
            cyc++;
            if (exp_rv && resp_ready_i) begin
                have_txn = 1'b0;
                resp_cnt++;
            end
            if (g >= 0) begin
                have_txn       = 1'b1;
                age            = 0;
                txn_id         = g;
                txn_p          = prod(va[g], vb[g]);
                last_g         = g;
                req_valid_i[g] = 1'b0;
            end else if (have_txn) begin
                age++;
            end
        end
        chk("rnd_resp_count", resp_cnt, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
